// File: rtl/uart_rx_pkg.sv
// Shared types and sample-point helpers for the UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // The three majority-vote ticks sit around the middle of each bit period.
    function automatic int sample_tick_first(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int sample_tick_mid(input int oversample);
        return oversample / 2;
    endfunction

    function automatic int sample_tick_last(input int oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period tick counter and 3-sample majority vote around the bit centre.
// bit_val_o is valid while sample_strobe_o is high; bit_end_o marks the final tick of a bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_s_i,
    input  logic tick_load_i,
    input  logic tick_load_one_i,
    output logic bit_val_o,
    output logic sample_strobe_o,
    output logic bit_end_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_FIRST = TW'(sample_tick_first(OVERSAMPLE));
    localparam logic [TW-1:0] T_MID   = TW'(sample_tick_mid(OVERSAMPLE));
    localparam logic [TW-1:0] T_LAST  = TW'(sample_tick_last(OVERSAMPLE));
    localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic          s0_q, s1_q;

    always_comb begin
        tick_d = tick_q;
        if (tick_load_i) begin
            tick_d = tick_load_one_i ? TW'(1) : '0;
        end else if (tick_q == T_END) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q <= '0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            tick_q <= tick_d;
            if (tick_q == T_FIRST) s0_q <= rx_s_i;
            if (tick_q == T_MID)   s1_q <= rx_s_i;
        end
    end

    assign bit_val_o       = (s0_q & s1_q) | (s0_q & rx_s_i) | (s1_q & rx_s_i);
    assign sample_strobe_o = (tick_q == T_LAST);
    assign bit_end_o       = (tick_q == T_END);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronised RX_IN, majority-voted bits, optional parity, stop check.
// Result pulses (DATA_VALID / PAR_ERR / STP_ERR) are registered and occupy the DONE cycle.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d, stp_bad_q, stp_bad_d;
    logic                  early_q, early_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  busy_q;
    logic                  bit_val, sample_strobe, bit_end;

    // A back-to-back start bit already seen in the last stop tick is one tick old on entering START.
    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk_i           (CLK),
        .rst_i           (RST),
        .rx_s_i          (rx_s_q),
        .tick_load_i     ((state_q == IDLE) || (state_q == DONE)),
        .tick_load_one_i ((state_q == DONE) && early_q),
        .bit_val_o       (bit_val),
        .sample_strobe_o (sample_strobe),
        .bit_end_o       (bit_end)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        stp_bad_d    = stp_bad_q;
        early_d      = early_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            START: begin
                if (sample_strobe && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            DATA: begin
                if (sample_strobe) shift_d[bit_cnt_q] = bit_val;
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (sample_strobe) par_bad_d = (^shift_q) ^ bit_val ^ (par_typ_q == PAR_ODD);
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (sample_strobe) stp_bad_d = ~bit_val;
                if (bit_end) begin
                    state_d = DONE;
                    early_d = ~rx_s_q;
                    if (!par_bad_q && !stp_bad_d) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        par_err_d = par_bad_q;
                        stp_err_d = stp_bad_d;
                    end
                end
            end
            DONE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_bad_q    <= 1'b0;
            stp_bad_q    <= 1'b0;
            early_q      <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            stp_bad_q    <= stp_bad_d;
            early_q      <= early_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign Busy       = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; sits directly downstream of the UART transmitter and consumes its serial TX_OUT line.
- Oversamples the serial input and recovers start, data, optional parity and stop bits.
- Presents the received word in parallel, with a one-cycle valid pulse and error flags.
- Frame format matches the transmitter: start 0, DATA_WIDTH bits LSB first, optional parity, stop 1.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, CLK cycles per bit period. Must be an even number, 4 or greater.

Ports:
- CLK  input  1  receiver clock, running at OVERSAMPLE x baud rate.
- RST  input  1  synchronous reset, active-high.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  input  1  1 = parity bit present in frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle pulse: P_DATA updated.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled low.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values: P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0, state=IDLE, synchronizer flops=1, counters=0.
- Reset mid-frame aborts the frame silently; no pulse is generated.
- RX_IN passes through a 2-flop synchronizer (rx_s). All logic uses rx_s only.
- Counters:
  - tick_cnt runs 0..OVERSAMPLE-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in the DATA state.
- Bit value is the majority of rx_s at tick_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The value is registered at tick OVERSAMPLE/2+1.
- States:
  - IDLE: rx_s=0 -> START with tick_cnt=0, and latch PAR_EN/PAR_TYP. Busy=0 only in IDLE.
  - START: at the sample point, majority=1 -> IDLE (glitch reject, no flags). Otherwise, at tick OVERSAMPLE-1 -> DATA.
  - DATA: shift the sampled bit into bit position bit_cnt (LSB first). At tick OVERSAMPLE-1 of bit DATA_WIDTH-1 -> PARITY if the latched PAR_EN=1, else -> STOP.
  - PARITY: parity check = XOR of data bits XOR received bit XOR PAR_TYP. A result of 1 means error. Move to STOP at tick OVERSAMPLE-1.
  - STOP: sample the stop bit. At tick OVERSAMPLE-1 -> DONE.
  - DONE: one cycle.
    - No error: P_DATA <= shift register and DATA_VALID=1.
    - Any error: P_DATA unchanged, DATA_VALID=0, and PAR_ERR/STP_ERR pulse as applicable (both may pulse together).
    - Next state is START if rx_s=0 this cycle, else IDLE. This allows back-to-back frames with no idle gap.
- Latency: let E0 be the first CLK edge that samples RX_IN low. DATA_VALID is high in the cycle following edge E0 + 2 + F*OVERSAMPLE, where F = 2 + DATA_WIDTH + PAR_EN. This is 82 cycles for 8N1 with OVERSAMPLE=8.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- Line held low (break condition): the frame completes with STP_ERR, then immediately restarts. No DATA_VALID is produced.
- Outputs are all registered.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE);
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - localparam helpers for the sample-point ticks.
- Sub-module uart_rx_sampler owns tick_cnt and the 3-sample majority. It outputs bit_val, a sample_strobe and a bit_end strobe.

Test Plan:
- 8N1, 0xA5, OVERSAMPLE=8 -> DATA_VALID pulses exactly once, 82 cycles after E0; P_DATA=0xA5; PAR_ERR=0, STP_ERR=0; Busy=1 throughout the frame.
- PAR_EN=1, PAR_TYP=0, 0x3C sent with parity 0 -> P_DATA=0x3C and DATA_VALID after 90 cycles. Same frame with parity 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x3C.
- Odd parity, 0x01 with parity 0 -> valid. Stop bit forced 0 -> STP_ERR pulse, P_DATA unchanged.
- RX_IN low for 3 cycles, then high -> START aborts; Busy returns to 0; no pulses.
- Two back-to-back 8N1 frames 0x55 then 0xFF with no idle gap -> two DATA_VALID pulses exactly 80 cycles apart, with the correct data each time.
- RST asserted at bit 4 of a frame, then a clean frame 0x81 -> no pulse from the aborted frame; 0x81 is received correctly.
